// File: rtl/ide_dma_master_if.sv
// rtl/ide_dma_master_if.sv - 68030 bus-master signal group for the IDE DMA engine
interface ide_dma_master_if;
    logic        br;
    logic        bg;
    logic        as_in;
    logic        bgack_in;
    logic        bgack;
    logic        bus_drive;
    logic [31:0] addr_out;
    logic [1:0]  siz_out;
    logic        rn_w_out;
    logic        as_out;
    logic        ds_out;
    logic [31:0] data_out;
    logic [1:0]  dsack;
    logic        berr;

    // DMA engine side: requests the bus and runs the write cycle
    modport master (
        output br, bgack, bus_drive, addr_out, siz_out, rn_w_out,
               as_out, ds_out, data_out,
        input  bg, as_in, bgack_in, dsack, berr
    );

    // Arbiter / addressed device side
    modport slave (
        input  br, bgack, bus_drive, addr_out, siz_out, rn_w_out,
               as_out, ds_out, data_out,
        output bg, as_in, bgack_in, dsack, berr
    );
endinterface

// File: rtl/ide_dma_master.sv
// rtl/ide_dma_master.sv - IDE-to-memory bus-master DMA engine for the 68030 bus
module ide_dma_master #(
    parameter int unsigned IDE_STROBE = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      mem_addr,
    input  logic [15:0]      word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    ide_dma_master_if.master bus,
    input  logic             ide_dma_req,
    output logic             ide_dma_ack,
    output logic             ide_read,
    input  logic [15:0]      ide_data
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_ZERO,
        S_REQ,
        S_OWN,
        S_WAIT_REQ,
        S_IDE_RD,
        S_ADDR,
        S_STROBE,
        S_END,
        S_ABORT,
        S_RELEASE
    } state_t;

    localparam logic [2:0] STROBE_LAST = 3'(IDE_STROBE);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [15:0] count_q;
    logic [15:0] word_q;
    logic [2:0]  str_q;
    logic [7:0]  tmo_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        br_q;
    logic        bgack_q;
    logic        drive_q;
    logic        as_q;
    logic        ack_q;

    // Transfer sequencer; every output is set on the transition into the state that owns it
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            str_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            br_q    <= 1'b0;
            bgack_q <= 1'b0;
            drive_q <= 1'b0;
            as_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        addr_q  <= {mem_addr[31:1], 1'b0};
                        count_q <= word_count;
                        if (word_count == 16'd0) begin
                            state_q <= S_ZERO;
                        end else begin
                            br_q    <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_ZERO: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_REQ: begin
                    // Only take the bus once the previous master has fully let go
                    if (bus.bg && !bus.as_in && !bus.bgack_in) begin
                        br_q    <= 1'b0;
                        bgack_q <= 1'b1;
                        drive_q <= 1'b1;
                        state_q <= S_OWN;
                    end
                end
                S_OWN: begin
                    state_q <= S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (ide_dma_req) begin
                        ack_q   <= 1'b1;
                        str_q   <= 3'd1;
                        state_q <= S_IDE_RD;
                    end
                end
                S_IDE_RD: begin
                    if (str_q == STROBE_LAST) begin
                        word_q  <= ide_data;
                        ack_q   <= 1'b0;
                        state_q <= S_ADDR;
                    end else begin
                        str_q <= str_q + 3'd1;
                    end
                end
                S_ADDR: begin
                    as_q    <= 1'b1;
                    tmo_q   <= 8'd1;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    // BERR outranks DSACK; an 8-bit port cannot take a word write
                    if (bus.berr || bus.dsack == 2'b01) begin
                        as_q    <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_ABORT;
                    end else if (bus.dsack[1]) begin
                        as_q    <= 1'b0;
                        state_q <= S_END;
                    end else if (tmo_q == TMO_LAST) begin
                        as_q    <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_ABORT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_END: begin
                    addr_q  <= addr_q + 32'd2;
                    count_q <= count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        bgack_q <= 1'b0;
                        drive_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_WAIT_REQ;
                    end
                end
                S_ABORT: begin
                    bgack_q <= 1'b0;
                    drive_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus lanes only carry values while we own the tristates
    assign bus.br        = br_q;
    assign bus.bgack     = bgack_q;
    assign bus.bus_drive = drive_q;
    assign bus.addr_out  = drive_q ? addr_q : 32'd0;
    assign bus.siz_out   = drive_q ? 2'b10 : 2'b00;
    assign bus.rn_w_out  = 1'b0;
    assign bus.as_out    = as_q;
    assign bus.ds_out    = as_q;
    assign bus.data_out  = drive_q ? {word_q, word_q} : 32'd0;

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign ide_dma_ack = ack_q;
    assign ide_read    = ack_q;
endmodule

// File: tb/tb_ide_dma_master.sv
// tb/tb_ide_dma_master.sv - self-checking bench for ide_dma_master
module tb_ide_dma_master;
    localparam int STROBE_N = 3;
    localparam int TMO_N    = 20;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] mem_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic        ide_dma_req;
    logic        ide_dma_ack;
    logic        ide_read;
    logic [15:0] ide_data;

    ide_dma_master_if bus ();

    ide_dma_master #(.IDE_STROBE(STROBE_N), .TIMEOUT(TMO_N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mem_addr    (mem_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .bus         (bus),
        .ide_dma_req (ide_dma_req),
        .ide_dma_ack (ide_dma_ack),
        .ide_read    (ide_read),
        .ide_data    (ide_data)
    );

    typedef struct {
        logic [31:0] addr;
        int          count;
        int          bg_dly;
        int          ds_dly;
        logic [1:0]  ds_val;
        int          fault_word;
        int          fault_kind;
        logic [15:0] seed;
        logic [15:0] step;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } wr_t;

    wr_t         sb_q[$];
    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_errors = 0;
    int          words_seen = 0;
    bit          skip_len = 0;
    bit          br_seen = 0;
    int          cfg_bg_dly = 0;
    int          cfg_ds_dly = 1;
    logic [1:0]  cfg_ds_val = 2'b11;
    int          cfg_fault_word = -1;
    int          cfg_fault_kind = 0;
    logic [15:0] cfg_seed = 16'h0;
    logic [15:0] cfg_step = 16'h0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arbiter/device/IDE model plus write monitor feeding off the scoreboard
    initial begin : bus_model
        int  br_cnt;
        int  as_len;
        int  ack_len;
        int  cur_word;
        int  len_exp;
        bit  as_prev;
        bit  ack_prev;
        wr_t e;
        br_cnt = 0; as_len = 0; ack_len = 0; cur_word = 0; len_exp = 0;
        as_prev = 0; ack_prev = 0;
        bus.bg = 1'b0; bus.dsack = 2'b00; bus.berr = 1'b0;
        ide_dma_req = 1'b0; ide_data = 16'h0;
        forever begin
            @(negedge clock);
            if (bus.as_out && !as_prev) begin
                cur_word = words_seen;
                words_seen++;
                as_len = 0;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    len_exp = 0;
                    $display("FAIL wr_unexpected: got write at 0x%0h expected none", bus.addr_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 64'(bus.addr_out), 64'(e.addr));
                    chk("wr_data", 64'(bus.data_out), 64'(e.data));
                    chk("wr_siz_rnw", 64'({bus.siz_out, bus.rn_w_out}), 64'(3'b100));
                    len_exp = e.len;
                end
            end
            if (bus.as_out) as_len++;
            else if (as_prev && !skip_len) chk("as_len", 64'(as_len), 64'(len_exp));
            if (ide_dma_ack) ack_len++;
            else begin
                if (ack_prev) chk("ack_len", 64'(ack_len), 64'(STROBE_N));
                ack_len = 0;
            end
            if (bus.br) br_seen = 1;
            as_prev  = bus.as_out;
            ack_prev = ide_dma_ack;

            br_cnt = bus.br ? br_cnt + 1 : 0;
            bus.bg = bus.br && (br_cnt > cfg_bg_dly);
            bus.dsack = 2'b00;
            bus.berr  = 1'b0;
            if (bus.as_out && as_len >= cfg_ds_dly) begin
                if (cur_word == cfg_fault_word) begin
                    if (cfg_fault_kind == 1) begin
                        bus.berr  = 1'b1;
                        bus.dsack = cfg_ds_val;
                    end else if (cfg_fault_kind == 2) begin
                        bus.dsack = 2'b01;
                    end
                end else begin
                    bus.dsack = cfg_ds_val;
                end
            end
            ide_dma_req = ($urandom_range(0, 3) != 0);
            ide_data    = cfg_seed + 16'(words_seen) * cfg_step;
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] c);
        start = 1'b1;
        mem_addr = a;
        word_count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clock);
            if (done) got = 1;
        end
        chk(name, 64'(got), 64'(1));
    endtask

    task automatic push_writes(input logic [31:0] a, input int n, input logic [15:0] seed,
                               input logic [15:0] step, input int last_len);
        wr_t e;
        logic [15:0] d;
        for (int k = 0; k < n; k++) begin
            d = seed + 16'(k) * step;
            e.addr = {a[31:1], 1'b0} + 32'(2 * k);
            e.data = {d, d};
            e.len  = (k == n - 1) ? last_len : cfg_ds_dly;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int nwr;
        int last_len;
        bit exp_err;
        cfg_bg_dly = v.bg_dly; cfg_ds_dly = v.ds_dly; cfg_ds_val = v.ds_val;
        cfg_fault_word = v.fault_word; cfg_fault_kind = v.fault_kind;
        cfg_seed = v.seed; cfg_step = v.step;
        exp_err  = (v.fault_kind != 0);
        nwr      = exp_err ? v.fault_word + 1 : v.count;
        last_len = (v.fault_kind == 3) ? TMO_N : v.ds_dly;
        words_seen = 0;
        push_writes(v.addr, nwr, v.seed, v.step, last_len);
        pulse_start(v.addr, 16'(v.count));
        chk($sformatf("v%0d_busy_err", idx), 64'({busy, error}), 64'(2'b10));
        if (idx == 0) begin
            repeat (3) @(negedge clock);
            pulse_start(32'hDEAD_0000, 16'd5);
        end
        wait_done($sformatf("v%0d_done", idx), 2000);
        chk($sformatf("v%0d_error", idx), 64'(error), 64'(exp_err));
        chk($sformatf("v%0d_release", idx), 64'({bus.br, bus.bgack, bus.bus_drive}), 64'(0));
        chk($sformatf("v%0d_writes", idx), 64'(words_seen), 64'(nwr));
        chk($sformatf("v%0d_sb_empty", idx), 64'(sb_q.size()), 64'(0));
        @(negedge clock);
        chk($sformatf("v%0d_idle", idx), 64'({busy, done}), 64'(0));
    endtask

    task automatic arb_seq(input bit use_bgack);
        bit early = 0;
        bit got = 0;
        cfg_bg_dly = 0; cfg_ds_dly = 1; cfg_ds_val = 2'b11;
        cfg_fault_word = -1; cfg_fault_kind = 0;
        cfg_seed = 16'h5A00; cfg_step = 16'h0001;
        words_seen = 0;
        if (use_bgack) bus.bgack_in = 1'b1;
        else bus.as_in = 1'b1;
        push_writes(32'h0070_0000, 1, cfg_seed, cfg_step, 1);
        pulse_start(32'h0070_0000, 16'd1);
        repeat (4) begin
            @(negedge clock);
            if (bus.bgack) early = 1;
        end
        chk(use_bgack ? "arb_bgack_in_hold" : "arb_as_in_hold", 64'({early, bus.br, bus.bg}), 64'(3'b011));
        bus.as_in = 1'b0;
        bus.bgack_in = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clock);
            if (bus.bgack) got = 1;
        end
        chk(use_bgack ? "arb_bgack_in_take" : "arb_as_in_take", 64'(got), 64'(1));
        wait_done("arb_done", 500);
        chk("arb_sb_empty", 64'(sb_q.size()), 64'(0));
        @(negedge clock);
    endtask

    initial begin : main
        bit any_done;
        bit seen_as;
        vecs[0] = '{32'h0010_0000, 3, 2, 1, 2'b11, -1, 0, 16'h1111, 16'h1111};
        vecs[1] = '{32'h0020_0001, 2, 0, 3, 2'b10, -1, 0, 16'hA5A5, 16'h0101};
        vecs[2] = '{32'hFFFF_FFFE, 2, 1, 2, 2'b11, -1, 0, 16'hBEEF, 16'h1000};
        vecs[3] = '{32'h0030_0000, 2, 1, 1, 2'b11,  0, 1, 16'h1234, 16'h1111};
        vecs[4] = '{32'h0034_0000, 2, 0, 1, 2'b10, -1, 0, 16'h0F0F, 16'h1010};
        vecs[5] = '{32'h0040_0000, 3, 0, 2, 2'b10,  1, 2, 16'h4321, 16'h0202};
        vecs[6] = '{32'h0050_0000, 1, 0, 1, 2'b11,  0, 3, 16'hCAFE, 16'h0001};

        reset = 1'b1; start = 1'b0; mem_addr = '0; word_count = '0;
        bus.as_in = 1'b0; bus.bgack_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_ctrl", 64'({busy, done, error, bus.br, bus.bgack, bus.bus_drive, bus.as_out, ide_dma_ack}), 64'(0));
        chk("reset_bus", 64'({bus.addr_out, bus.data_out}), 64'(0));

        for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);

        br_seen = 0;
        pulse_start(32'h0060_0000, 16'd0);
        chk("zero_c1", 64'({busy, done, error}), 64'(3'b100));
        @(negedge clock);
        chk("zero_c2", 64'({busy, done}), 64'(2'b01));
        @(negedge clock);
        chk("zero_c3", 64'({busy, done, br_seen}), 64'(0));

        arb_seq(1'b0);
        arb_seq(1'b1);

        cfg_fault_word = 0; cfg_fault_kind = 3; cfg_ds_dly = 1;
        words_seen = 0;
        push_writes(32'h0080_0000, 1, cfg_seed, cfg_step, TMO_N);
        pulse_start(32'h0080_0000, 16'd1);
        seen_as = 0;
        for (int i = 0; i < 200 && !seen_as; i++) begin
            @(negedge clock);
            if (bus.as_out) seen_as = 1;
        end
        chk("rst_reach_strobe", 64'(seen_as), 64'(1));
        @(negedge clock);
        skip_len = 1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_ctrl", 64'({busy, done, error, bus.br, bus.bgack, bus.bus_drive,
                                 bus.as_out, bus.ds_out, ide_dma_ack, ide_read}), 64'(0));
        chk("rst_mid_bus", 64'({bus.addr_out, bus.data_out}), 64'(0));
        reset = 1'b0;
        any_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || busy) any_done = 1;
        end
        chk("rst_no_done", 64'(any_done), 64'(0));
        skip_len = 0;
        chk("rst_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
